// File: rtl/matmul_pkg.sv
// Shared sizing parameters, element/row/matrix types and FSM states
// for the result-matrix scratchpad.
package matmul_pkg;

  localparam int BUS_WIDTH   = 32;
  localparam int MAX_DIM     = 4;
  localparam int SP_NTARGETS = 4;

  localparam int BANK_W = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1;
  localparam int IDX_W  = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int DIM_W  = IDX_W + 1;

  typedef logic [BUS_WIDTH-1:0] elem_t;
  typedef elem_t [MAX_DIM-1:0]  row_t;
  typedef row_t  [MAX_DIM-1:0]  mat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/matmul_sp_if.sv
// Capture control, row stream, element read port and full-bank view
// of the scratchpad, bundled for the master (producer) and slave (scratchpad).
interface matmul_sp_if;
  import matmul_pkg::*;

  logic              start_i;
  logic [BANK_W-1:0] bank_i;
  logic              acc_i;
  logic [DIM_W-1:0]  dim_i;

  logic              row_valid_i;
  row_t              row_data_i;
  logic              row_ready_o;

  logic              rd_en_i;
  logic [BANK_W-1:0] rd_bank_i;
  logic [IDX_W-1:0]  rd_row_i;
  logic [IDX_W-1:0]  rd_col_i;
  elem_t             rd_data_o;
  logic              rd_valid_o;

  logic [BANK_W-1:0] view_bank_i;
  mat_t              dataSp_o;

  logic              busy_o;
  logic              done_o;
  logic              overflow_o;

  modport master (
    output start_i, bank_i, acc_i, dim_i, row_valid_i, row_data_i,
           rd_en_i, rd_bank_i, rd_row_i, rd_col_i, view_bank_i,
    input  row_ready_o, rd_data_o, rd_valid_o, dataSp_o,
           busy_o, done_o, overflow_o
  );

  modport slave (
    input  start_i, bank_i, acc_i, dim_i, row_valid_i, row_data_i,
           rd_en_i, rd_bank_i, rd_row_i, rd_col_i, view_bank_i,
    output row_ready_o, rd_data_o, rd_valid_o, dataSp_o,
           busy_o, done_o, overflow_o
  );

endinterface

// File: rtl/matmul_sp_acc.sv
// One element lane: pass the incoming value through, or add it to the stored
// value with two's-complement wrap and flag signed overflow.
module matmul_sp_acc
  import matmul_pkg::*;
(
  input  logic  acc,
  input  elem_t old_val,
  input  elem_t in_val,
  output elem_t result,
  output logic  ovf
);

  elem_t sum;

  assign sum    = old_val + in_val;
  assign result = acc ? sum : in_val;
  // Signed overflow: operands share a sign and the wrapped sum does not.
  assign ovf    = acc && (old_val[BUS_WIDTH-1] == in_val[BUS_WIDTH-1])
                      && (sum[BUS_WIDTH-1] != old_val[BUS_WIDTH-1]);

endmodule

// File: rtl/matmul_sp.sv
// Banked scratchpad that captures a result matrix row by row (overwrite or
// accumulate), with a 1-cycle element read port and a full-bank view.
module matmul_sp
  import matmul_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  matmul_sp_if.slave    bus
);

  state_t            state, state_nxt;
  mat_t              mem [SP_NTARGETS];

  logic [BANK_W-1:0] bank_q;
  logic              acc_q;
  logic [DIM_W-1:0]  dim_q;
  logic [IDX_W-1:0]  row_cnt;
  logic              overflow_q;
  elem_t             rd_data_q;
  logic              rd_valid_q;

  logic              start_ok;
  logic              row_we;
  logic              last_row;
  elem_t             lane_res [MAX_DIM];
  logic              lane_ovf [MAX_DIM];
  row_t              row_new;
  logic              row_ovf;

  assign start_ok = bus.start_i && (bus.dim_i != '0) && (bus.dim_i <= DIM_W'(MAX_DIM));
  assign row_we   = (state == WRITE) && bus.row_valid_i;
  assign last_row = ({1'b0, row_cnt} == (dim_q - DIM_W'(1)));

  for (genvar j = 0; j < MAX_DIM; j++) begin : g_lane
    matmul_sp_acc u_acc (
      .acc     (acc_q),
      .old_val (mem[bank_q][row_cnt][j]),
      .in_val  (bus.row_data_i[j]),
      .result  (lane_res[j]),
      .ovf     (lane_ovf[j])
    );
  end

  always_comb begin
    row_new = '0;
    row_ovf = 1'b0;
    for (int j = 0; j < MAX_DIM; j++) begin
      row_new[j] = lane_res[j];
      row_ovf    = row_ovf | lane_ovf[j];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = WRITE;
      WRITE:   if (row_we && last_row) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.row_ready_o = (state == WRITE);
  assign bus.busy_o      = (state != IDLE);
  assign bus.done_o      = (state == DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q     <= '0;
      acc_q      <= 1'b0;
      dim_q      <= '0;
      row_cnt    <= '0;
      overflow_q <= 1'b0;
    end else if ((state == IDLE) && start_ok) begin
      bank_q     <= bus.bank_i;
      acc_q      <= bus.acc_i;
      dim_q      <= bus.dim_i;
      row_cnt    <= '0;
      overflow_q <= 1'b0;
    end else if (row_we) begin
      row_cnt <= row_cnt + IDX_W'(1);
      if (row_ovf) overflow_q <= 1'b1;
    end
  end

  assign bus.overflow_o = overflow_q;

  // NOTE: the storage is reset on purpose -- an aborted capture must leave every bank zeroed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < SP_NTARGETS; b++) mem[b] <= '0;
    end else if (row_we) begin
      mem[bank_q][row_cnt] <= row_new;
    end
  end

  // NOTE: non-blocking updates make a same-edge read see the pre-write contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_en_i;
      if (bus.rd_en_i) rd_data_q <= mem[bus.rd_bank_i][bus.rd_row_i][bus.rd_col_i];
    end
  end

  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_data_o  = rd_data_q;
  assign bus.dataSp_o   = mem[bus.view_bank_i];

endmodule

// File: tb/tb_matmul_sp.sv
// Directed plus randomized bench for matmul_sp, compared against a plain
// array model of the banks that applies the overwrite/accumulate rules.
module tb_matmul_sp;
  import matmul_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matmul_sp_if bus();

  matmul_sp dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [BUS_WIDTH-1:0] model [SP_NTARGETS][MAX_DIM][MAX_DIM];
  logic model_ovf;
  int   cap_bank, cap_acc, cap_dim, cap_row;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic row_t mk_row(input logic [31:0] a, b, c, d);
    row_t r;
    r = '0;
    r[0] = BUS_WIDTH'(a);
    r[1] = BUS_WIDTH'(b);
    r[2] = BUS_WIDTH'(c);
    r[3] = BUS_WIDTH'(d);
    return r;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int j = 0; j < MAX_DIM; j++) r[j] = BUS_WIDTH'($urandom);
    return r;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < SP_NTARGETS; b++)
      for (int r = 0; r < MAX_DIM; r++)
        for (int c = 0; c < MAX_DIM; c++) model[b][r][c] = '0;
    model_ovf = 1'b0;
  endtask

  // Reference: overwrite, or signed add with wrap and out-of-range detection.
  task automatic model_write(input int b, input int r, input int acc, input row_t data);
    longint s;
    for (int c = 0; c < MAX_DIM; c++) begin
      if (acc != 0) begin
        s = longint'($signed(model[b][r][c])) + longint'($signed(data[c]));
        if (s > 64'sd2147483647 || s < -64'sd2147483648) model_ovf = 1'b1;
        model[b][r][c] = model[b][r][c] + data[c];
      end else begin
        model[b][r][c] = data[c];
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int b = 0; b < SP_NTARGETS; b++) begin
      bus.view_bank_i = BANK_W'(b);
      #1;
      for (int r = 0; r < MAX_DIM; r++)
        for (int c = 0; c < MAX_DIM; c++)
          check($sformatf("%s b%0d r%0d c%0d", tag, b, r, c),
                64'(bus.dataSp_o[r][c]), 64'(model[b][r][c]));
    end
  endtask

  task automatic start_cap(input int b, input int acc, input int d);
    bus.start_i = 1'b1;
    bus.bank_i  = BANK_W'(b);
    bus.acc_i   = acc[0];
    bus.dim_i   = DIM_W'(d);
    tick();
    bus.start_i = 1'b0;
    cap_bank = b; cap_acc = acc; cap_dim = d; cap_row = 0;
    model_ovf = 1'b0;
    check("start_busy", 64'(bus.busy_o), 64'd1);
    check("start_ready", 64'(bus.row_ready_o), 64'd1);
  endtask

  task automatic send_row(input row_t data, input bit gap);
    bus.row_valid_i = 1'b1;
    bus.row_data_i  = data;
    tick();
    bus.row_valid_i = 1'b0;
    bus.row_data_i  = rand_row();
    model_write(cap_bank, cap_row, cap_acc, data);
    cap_row++;
    if (gap && cap_row < cap_dim) tick();
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done"}, 64'(bus.done_o), 64'd1);
    check({tag, "_done_busy"}, 64'(bus.busy_o), 64'd1);
    check({tag, "_done_ready"}, 64'(bus.row_ready_o), 64'd0);
    tick();
    check({tag, "_done_off"}, 64'(bus.done_o), 64'd0);
    check({tag, "_idle"}, 64'(bus.busy_o), 64'd0);
  endtask

  task automatic read_check(input int b, input int r, input int c);
    bus.rd_en_i   = 1'b1;
    bus.rd_bank_i = BANK_W'(b);
    bus.rd_row_i  = IDX_W'(r);
    bus.rd_col_i  = IDX_W'(c);
    tick();
    bus.rd_en_i = 1'b0;
    check("rd_valid", 64'(bus.rd_valid_o), 64'd1);
    check($sformatf("rd_data b%0d r%0d c%0d", b, r, c), 64'(bus.rd_data_o), 64'(model[b][r][c]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    row_t d;
    logic [BUS_WIDTH-1:0] old;

    bus.start_i = 0; bus.bank_i = '0; bus.acc_i = 0; bus.dim_i = '0;
    bus.row_valid_i = 0; bus.row_data_i = '0;
    bus.rd_en_i = 0; bus.rd_bank_i = '0; bus.rd_row_i = '0; bus.rd_col_i = '0;
    bus.view_bank_i = '0;
    model_clear();

    // Reset state
    #3;
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_ready", 64'(bus.row_ready_o), 64'd0);
    check("rst_ovf", 64'(bus.overflow_o), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid_o), 64'd0);
    check("rst_rd_data", 64'(bus.rd_data_o), 64'd0);
    compare_all("rst_mem");
    #10 rst_n = 1'b1;
    tick();

    // Overwrite, bank 1, two rows
    start_cap(1, 0, 2);
    send_row(mk_row(1, 2, 3, 4), 0);
    check("ow_not_done_yet", 64'(bus.done_o), 64'd0);
    send_row(mk_row(5, 6, 7, 8), 0);
    expect_done("ow");
    compare_all("ow_mem");
    read_check(1, 1, 2);
    check("ow_b1r1c2_const", 64'(bus.rd_data_o), 64'd7);

    // Accumulate the same rows
    start_cap(1, 1, 2);
    send_row(mk_row(1, 2, 3, 4), 0);
    send_row(mk_row(5, 6, 7, 8), 0);
    expect_done("acc");
    compare_all("acc_mem");
    read_check(1, 0, 1);
    check("acc_b1r0c1_const", 64'(bus.rd_data_o), 64'd4);
    check("acc_ovf", 64'(bus.overflow_o), 64'd0);

    // Signed overflow on accumulate
    start_cap(0, 0, 1);
    send_row(mk_row(32'h7FFF_FFFF, 0, 0, 0), 0);
    expect_done("ovf_pre");
    start_cap(0, 1, 1);
    send_row(mk_row(1, 0, 0, 0), 0);
    expect_done("ovf");
    check("ovf_flag", 64'(bus.overflow_o), 64'(model_ovf));
    check("ovf_flag_const", 64'(bus.overflow_o), 64'd1);
    read_check(0, 0, 0);
    check("ovf_wrap_const", 64'(bus.rd_data_o), 64'h8000_0000);
    repeat (3) tick();
    check("ovf_sticky", 64'(bus.overflow_o), 64'd1);
    start_cap(2, 0, 1);
    check("ovf_cleared", 64'(bus.overflow_o), 64'd0);
    send_row(rand_row(), 0);
    expect_done("ovf_post");

    // Backpressure with ignored mid-capture start, bank 2 full matrix
    start_cap(2, 0, 4);
    send_row(rand_row(), 1);
    bus.start_i = 1'b1; bus.bank_i = 2'd3; bus.dim_i = 3'd1; bus.acc_i = 1'b0;
    check("bp_ready_gap", 64'(bus.row_ready_o), 64'd1);
    send_row(rand_row(), 1);
    bus.start_i = 1'b0;
    send_row(rand_row(), 1);
    send_row(rand_row(), 1);
    expect_done("bp");
    compare_all("bp_mem");

    // Illegal dims are ignored
    bus.start_i = 1'b1; bus.dim_i = '0; bus.bank_i = 2'd3;
    tick();
    check("dim0_busy", 64'(bus.busy_o), 64'd0);
    check("dim0_ready", 64'(bus.row_ready_o), 64'd0);
    bus.dim_i = DIM_W'(MAX_DIM + 1);
    tick();
    bus.start_i = 1'b0;
    check("dim5_busy", 64'(bus.busy_o), 64'd0);

    // Read collides with the write of the same element
    start_cap(1, 0, 1);
    old = model[1][0][0];
    d = rand_row();
    bus.rd_en_i = 1'b1; bus.rd_bank_i = 2'd1; bus.rd_row_i = '0; bus.rd_col_i = '0;
    send_row(d, 0);
    bus.rd_en_i = 1'b0;
    check("col_rd_valid", 64'(bus.rd_valid_o), 64'd1);
    check("col_rd_old", 64'(bus.rd_data_o), 64'(old));
    expect_done("col");
    check("col_rd_valid_off", 64'(bus.rd_valid_o), 64'd0);
    check("col_rd_hold", 64'(bus.rd_data_o), 64'(old));
    read_check(1, 0, 0);

    // Randomized captures and reads
    for (int n = 0; n < 12; n++) begin
      start_cap(int'($urandom_range(0, SP_NTARGETS - 1)), int'($urandom_range(0, 1)),
                int'($urandom_range(1, MAX_DIM)));
      for (int r = cap_row; r < cap_dim; r++) send_row(rand_row(), bit'($urandom_range(0, 1)));
      expect_done("rnd");
      check("rnd_ovf", 64'(bus.overflow_o), 64'(model_ovf));
    end
    compare_all("rnd_mem");
    for (int n = 0; n < 16; n++)
      read_check(int'($urandom_range(0, SP_NTARGETS - 1)), int'($urandom_range(0, MAX_DIM - 1)),
                 int'($urandom_range(0, MAX_DIM - 1)));

    // Reset in the middle of a capture
    start_cap(3, 0, 3);
    send_row(rand_row(), 0);
    rst_n = 1'b0;
    #1;
    model_clear();
    check("mid_rst_busy", 64'(bus.busy_o), 64'd0);
    check("mid_rst_done", 64'(bus.done_o), 64'd0);
    check("mid_rst_ready", 64'(bus.row_ready_o), 64'd0);
    check("mid_rst_ovf", 64'(bus.overflow_o), 64'd0);
    check("mid_rst_rd_valid", 64'(bus.rd_valid_o), 64'd0);
    check("mid_rst_rd_data", 64'(bus.rd_data_o), 64'd0);
    compare_all("mid_rst_mem");
    tick();
    check("mid_rst_no_done", 64'(bus.done_o), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_idle", 64'(bus.busy_o), 64'd0);
    start_cap(3, 1, 2);
    send_row(rand_row(), 0);
    send_row(rand_row(), 0);
    expect_done("post_rst");
    compare_all("post_rst_mem");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_sp.md
MATMUL_SP -- requirements
Module: matmul_sp

Interface
REQ-001 Parameters SHALL be taken from matmul_pkg: BUS_WIDTH (default 32, element width), MAX_DIM (default 4, matrix side), SP_NTARGETS (default 4, number of banks).
REQ-002 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 start_i  in  1  request to capture one result matrix C.
REQ-005 bank_i  in  log2(SP_NTARGETS)  target bank; latched on an accepted start.
REQ-006 acc_i  in  1  1 = accumulate onto bank contents, 0 = overwrite; latched on an accepted start.
REQ-007 dim_i  in  log2(MAX_DIM)+1  number of rows to capture (1..MAX_DIM); latched on an accepted start.
REQ-008 row_valid_i / row_data_i / row_ready_o  in / in / out  1 / MAX_DIM*BUS_WIDTH / 1  valid-ready row stream; element j at bits [j*BUS_WIDTH +: BUS_WIDTH].
REQ-009 rd_en_i, rd_bank_i, rd_row_i, rd_col_i  in  1 / bank / log2(MAX_DIM) / log2(MAX_DIM)  element read request.
REQ-010 rd_data_o / rd_valid_o  out  BUS_WIDTH / 1  read data and its qualifier.
REQ-011 view_bank_i  in  bank width  bank exported on dataSp_o.
REQ-012 dataSp_o  out  [MAX_DIM][MAX_DIM] x BUS_WIDTH  combinational full view of bank view_bank_i; this array is the dataSp signal the checker compares against the reference C.
REQ-013 busy_o, done_o, overflow_o  out  1 each  capture in progress; one-cycle completion pulse; sticky accumulate overflow.

Function
REQ-014 Storage SHALL be SP_NTARGETS x MAX_DIM x MAX_DIM flops of BUS_WIDTH signed bits.
REQ-015 FSM states SHALL be IDLE, WRITE, DONE; the reset state SHALL be IDLE.
REQ-016 IDLE->WRITE SHALL occur when start_i=1 and dim_i is in 1..MAX_DIM. The block SHALL latch bank_i, acc_i and dim_i, clear the row counter and clear overflow_o.
REQ-017 start_i with dim_i=0 or dim_i>MAX_DIM SHALL be ignored. start_i in WRITE or DONE SHALL be ignored.
REQ-018 In WRITE, row_ready_o SHALL be 1; in IDLE and DONE it SHALL be 0.
REQ-019 When row_valid_i=1 and row_ready_o=1, row <row counter> of the latched bank SHALL be written in that same edge, and the counter SHALL increment.
REQ-020 Overwrite mode: each stored element SHALL equal the input element.
REQ-021 Accumulate mode: each stored element SHALL equal old + input, two's-complement wrap to BUS_WIDTH. Signed overflow on any element SHALL set overflow_o, which holds until the next accepted start.
REQ-022 After the row with index dim-1 is accepted, the FSM SHALL go to DONE. Rows >= dim SHALL remain untouched.
REQ-023 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-024 busy_o SHALL be 1 in WRITE and DONE.
REQ-025 Reads SHALL have 1-cycle latency: rd_valid_o=rd_en_i delayed one cycle, and rd_data_o=element sampled at the request edge.
REQ-026 A read of an element being written in the same cycle SHALL return the old value (read-before-write).
REQ-027 When rd_valid_o=0, rd_data_o SHALL hold its last value.
REQ-028 dataSp_o SHALL reflect writes in the cycle after the write edge.

Reset
REQ-029 While rst_ni=0, the block SHALL clear all storage, rd_data_o, rd_valid_o, done_o, overflow_o, busy_o, row_ready_o and the counters to 0, and return the FSM to IDLE.
REQ-030 Reset during WRITE SHALL abort the capture with no done_o pulse. Rows already written SHALL also be cleared.

Structure
REQ-031 BUS_WIDTH, MAX_DIM, SP_NTARGETS and the FSM state enum typedef SHALL live in matmul_pkg.
REQ-032 One sub-module, matmul_sp_acc, SHALL implement the per-element add/pass-through with overflow detect, instantiated MAX_DIM times.

Verification
REQ-033 Overwrite: start bank=1, dim=2, acc=0; rows {1,2,3,4},{5,6,7,8} -> bank1 rows0-1 hold those values; row2 stays 0; done_o pulses 1 cycle after the second row is accepted.
REQ-034 Accumulate: repeat REQ-033 with acc=1 -> bank1 row0 = {2,4,6,8}; overflow_o=0.
REQ-035 Overflow: bank0[0][0]=0x7FFFFFFF, accumulate input 1 -> element reads 0x80000000 and overflow_o=1 until the next start.
REQ-036 Backpressure and ignore: row_valid_i toggles 1/0 each cycle -> rows are written in order. start_i mid-WRITE is ignored. dim_i=0 leaves the FSM in IDLE.
REQ-037 Read collision: rd_en_i at bank1/row0/col0 on the same edge as that row's write -> rd_data_o returns the old value next cycle, and rd_valid_o=1 for exactly 1 cycle.
REQ-038 Reset mid-WRITE after 1 row -> all outputs 0, storage 0, no done_o; a new start then completes normally.
